// File: rtl/capture_sequencer.sv
// capture_sequencer: arms the trigger block, waits a post-trigger offset, then writes
// N fixed-length segments into a linear sample buffer and reports done/overflow/abort.
module capture_sequencer #(
  parameter int ADDR_W = 14,
  parameter int SEG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_req_i,
  input  logic              abort_i,
  input  logic              ack_i,
  input  logic              trigger_i,
  input  logic [31:0]       offset_i,
  input  logic [31:0]       samples_i,
  input  logic [SEG_W-1:0]  segments_i,
  output logic              arm_o,
  output logic              sample_we_o,
  output logic [ADDR_W-1:0] sample_addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o,
  output logic              aborted_o,
  output logic [SEG_W-1:0]  seg_count_o,
  output logic [2:0]        state_o
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    REARM   = 3'd4,
    DONE    = 3'd5
  } state_t;
  state_t state, state_nx;
  logic [31:0] offset_q, last_q, dly_cnt, wr_cnt;
  logic [SEG_W-1:0] seg_q, seg_cnt;
  logic [SEG_W:0] seg_inc;
  logic [ADDR_W-1:0] addr;
  logic done_q, ovf_q, abt_q;
  logic busy, start, kill, seg_end, run_end, ovf_hit;
  always_comb begin
    busy    = state != IDLE && state != DONE;
    start   = arm_req_i && !busy;
    kill    = abort_i && busy;
    seg_inc = {1'b0, seg_cnt} + (SEG_W+1)'(1);
    seg_end = state == CAPTURE && wr_cnt == last_q;
    run_end = seg_end && seg_inc >= {1'b0, seg_q};
    // last buffer slot written while the run still wants more samples
    ovf_hit = state == CAPTURE && (&addr) && !run_end;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (kill) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = start ? ARMED : IDLE;
        ARMED:   state_nx = !trigger_i ? ARMED : offset_q == 32'd0 ? CAPTURE : DELAY;
        DELAY:   state_nx = dly_cnt == 32'd0 ? CAPTURE : DELAY;
        CAPTURE: state_nx = (ovf_hit || run_end) ? DONE : seg_end ? REARM : CAPTURE;
        REARM:   state_nx = trigger_i ? REARM : ARMED;
        DONE:    state_nx = start ? ARMED : ack_i ? IDLE : DONE;
        default: state_nx = IDLE;
      endcase
    end
  end
  always_comb begin
    arm_o         = state == ARMED;
    sample_we_o   = state == CAPTURE;
    busy_o        = busy;
    state_o       = state;
    sample_addr_o = addr;
    done_o        = done_q;
    overflow_o    = ovf_q;
    aborted_o     = abt_q;
    seg_count_o   = seg_cnt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset_q <= '0;
      last_q   <= '0;
      seg_q    <= '0;
      dly_cnt  <= '0;
      wr_cnt   <= '0;
      seg_cnt  <= '0;
      addr     <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      abt_q    <= 1'b0;
    end else if (start) begin
      offset_q <= offset_i;
      last_q   <= samples_i == 32'd0 ? 32'd0 : samples_i - 32'd1;
      seg_q    <= segments_i == '0 ? SEG_W'(1) : segments_i;
      wr_cnt   <= '0;
      seg_cnt  <= '0;
      addr     <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      abt_q    <= 1'b0;
    end else if (kill) begin
      abt_q <= 1'b1;
    end else begin
      if (!busy && ack_i) begin
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
        abt_q  <= 1'b0;
      end
      if (state == ARMED && trigger_i) begin
        dly_cnt <= offset_q - 32'd1;
        wr_cnt  <= '0;
      end
      if (state == DELAY) dly_cnt <= dly_cnt - 32'd1;
      if (state == CAPTURE) begin
        if (!(&addr)) addr <= addr + ADDR_W'(1);
        wr_cnt <= seg_end ? 32'd0 : wr_cnt + 32'd1;
        if (seg_end) seg_cnt <= seg_inc[SEG_W-1:0];
        if (ovf_hit) ovf_q <= 1'b1;
        else if (run_end) done_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed scenarios for capture_sequencer with a 16-entry buffer
// so the overflow boundary is reachable in a short run.
module tb_capture_sequencer;
  localparam int ADDR_W = 4;
  localparam int SEG_W  = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic arm_req_i = 1'b0, abort_i = 1'b0, ack_i = 1'b0, trigger_i = 1'b0;
  logic [31:0] offset_i = '0, samples_i = '0;
  logic [SEG_W-1:0] segments_i = '0;
  logic arm_o, sample_we_o, busy_o, done_o, overflow_o, aborted_o;
  logic [ADDR_W-1:0] sample_addr_o;
  logic [SEG_W-1:0] seg_count_o;
  logic [2:0] state_o;
  int n_chk = 0;
  int n_fail = 0;

  capture_sequencer #(.ADDR_W(ADDR_W), .SEG_W(SEG_W)) dut (
    .clk(clk), .reset(reset), .arm_req_i(arm_req_i), .abort_i(abort_i), .ack_i(ack_i),
    .trigger_i(trigger_i), .offset_i(offset_i), .samples_i(samples_i), .segments_i(segments_i),
    .arm_o(arm_o), .sample_we_o(sample_we_o), .sample_addr_o(sample_addr_o), .busy_o(busy_o),
    .done_o(done_o), .overflow_o(overflow_o), .aborted_o(aborted_o),
    .seg_count_o(seg_count_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // config is scrambled after the arm cycle to prove it was latched
  task automatic start_run(input logic [31:0] off, input logic [31:0] samp, input logic [SEG_W-1:0] seg);
    offset_i = off;
    samples_i = samp;
    segments_i = seg;
    arm_req_i = 1'b1;
    tick();
    arm_req_i = 1'b0;
    offset_i = 32'd7;
    samples_i = 32'd3;
    segments_i = 8'd2;
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state_o); end
    n_chk++; if ({arm_o, sample_we_o, busy_o, done_o, overflow_o, aborted_o} !== 6'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 000000", {arm_o, sample_we_o, busy_o, done_o, overflow_o, aborted_o}); end
    n_chk++; if (sample_addr_o !== 4'd0 || seg_count_o !== 8'd0) begin n_fail++; $display("FAIL reset_counts got addr %0d seg %0d exp 0 0", sample_addr_o, seg_count_o); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start_run(32'd0, 32'd4, 8'd1);
    n_chk++; if (arm_o !== 1'b1 || state_o !== 3'd1) begin n_fail++; $display("FAIL basic_armed got arm %0b state %0d exp 1 1", arm_o, state_o); end
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    n_chk++; if (arm_o !== 1'b0) begin n_fail++; $display("FAIL basic_arm_drop got %0b exp 0", arm_o); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (sample_we_o !== 1'b1 || sample_addr_o !== 4'(i)) begin n_fail++; $display("FAIL basic_write%0d got we %0b addr %0d exp 1 %0d", i, sample_we_o, sample_addr_o, i); end
      tick();
    end
    n_chk++; if (done_o !== 1'b1 || sample_we_o !== 1'b0 || state_o !== 3'd5) begin n_fail++; $display("FAIL basic_done got done %0b we %0b state %0d exp 1 0 5", done_o, sample_we_o, state_o); end
    n_chk++; if (seg_count_o !== 8'd1 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL basic_status got seg %0d ovf %0b exp 1 0", seg_count_o, overflow_o); end
    do_ack();
    n_chk++; if (done_o !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL basic_ack got done %0b state %0d exp 0 0", done_o, state_o); end
  endtask

  task automatic test_offset();
    start_run(32'd10, 32'd2, 8'd1);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      n_chk++; if (sample_we_o !== 1'b0) begin n_fail++; $display("FAIL offset_early_we at T+%0d got 1 exp 0", k); end
      tick();
    end
    n_chk++; if (sample_we_o !== 1'b1 || sample_addr_o !== 4'd0) begin n_fail++; $display("FAIL offset_first got we %0b addr %0d exp 1 0", sample_we_o, sample_addr_o); end
    tick();
    n_chk++; if (sample_we_o !== 1'b1 || sample_addr_o !== 4'd1) begin n_fail++; $display("FAIL offset_second got we %0b addr %0d exp 1 1", sample_we_o, sample_addr_o); end
    tick();
    n_chk++; if (done_o !== 1'b1 || sample_we_o !== 1'b0) begin n_fail++; $display("FAIL offset_done got done %0b we %0b exp 1 0", done_o, sample_we_o); end
    do_ack();
  endtask

  task automatic test_multi_segment();
    int nwr = 0;
    start_run(32'd0, 32'd5, 8'd3);
    for (int i = 0; i < 40; i++) begin
      trigger_i = (i < 20) || (i == 22) || (i == 31);
      tick();
      if (sample_we_o) begin
        n_chk++; if (sample_addr_o !== 4'(nwr)) begin n_fail++; $display("FAIL multi_addr got %0d exp %0d", sample_addr_o, nwr); end
        nwr++;
      end
      if (i == 19) begin
        n_chk++; if (nwr != 5 || seg_count_o !== 8'd1) begin n_fail++; $display("FAIL multi_long_trigger got writes %0d seg %0d exp 5 1", nwr, seg_count_o); end
      end
    end
    trigger_i = 1'b0;
    n_chk++; if (nwr != 15) begin n_fail++; $display("FAIL multi_writes got %0d exp 15", nwr); end
    n_chk++; if (seg_count_o !== 8'd3 || done_o !== 1'b1 || state_o !== 3'd5) begin n_fail++; $display("FAIL multi_done got seg %0d done %0b state %0d exp 3 1 5", seg_count_o, done_o, state_o); end
    do_ack();
  endtask

  task automatic test_overflow();
    int nwr;
    for (int b = 0; b < 2; b++) begin
      nwr = 0;
      start_run(32'd0, b == 0 ? 32'd20 : 32'd16, 8'd1);
      trigger_i = 1'b1;
      tick();
      trigger_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (sample_we_o) begin
          n_chk++; if (sample_addr_o !== 4'(nwr)) begin n_fail++; $display("FAIL ovf%0d_addr got %0d exp %0d", b, sample_addr_o, nwr); end
          nwr++;
        end
        tick();
      end
      n_chk++; if (nwr != 16) begin n_fail++; $display("FAIL ovf%0d_writes got %0d exp 16", b, nwr); end
      n_chk++; if (overflow_o !== (b == 0) || done_o !== (b == 1) || state_o !== 3'd5) begin n_fail++; $display("FAIL ovf%0d_flags got ovf %0b done %0b state %0d exp %0b %0b 5", b, overflow_o, done_o, state_o, b == 0, b == 1); end
    end
    ack_i = 1'b1;
    arm_req_i = 1'b1;
    tick();
    ack_i = 1'b0;
    arm_req_i = 1'b0;
    n_chk++; if (state_o !== 3'd1 || done_o !== 1'b0) begin n_fail++; $display("FAIL ack_arm_race got state %0d done %0b exp 1 0", state_o, done_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_chk++; if (state_o !== 3'd0 || aborted_o !== 1'b1 || arm_o !== 1'b0) begin n_fail++; $display("FAIL abort_armed got state %0d aborted %0b arm %0b exp 0 1 0", state_o, aborted_o, arm_o); end
    do_ack();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_chk++; if (aborted_o !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL abort_idle got aborted %0b state %0d exp 0 0", aborted_o, state_o); end
  endtask

  task automatic test_abort_delay();
    int nwr = 0;
    start_run(32'd100, 32'd4, 8'd1);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    for (int i = 1; i < 50; i++) begin
      if (sample_we_o) nwr++;
      tick();
    end
    n_chk++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL abort_in_delay got state %0d exp 2", state_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_chk++; if (state_o !== 3'd0 || aborted_o !== 1'b1 || done_o !== 1'b0) begin n_fail++; $display("FAIL abort_delay got state %0d aborted %0b done %0b exp 0 1 0", state_o, aborted_o, done_o); end
    for (int i = 0; i < 120; i++) begin
      if (sample_we_o) nwr++;
      tick();
    end
    n_chk++; if (nwr != 0) begin n_fail++; $display("FAIL abort_writes got %0d exp 0", nwr); end
    do_ack();
    n_chk++; if (aborted_o !== 1'b0) begin n_fail++; $display("FAIL abort_ack got %0b exp 0", aborted_o); end
  endtask

  task automatic test_async_reset();
    start_run(32'd0, 32'd8, 8'd1);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    n_chk++; if (state_o !== 3'd0 || sample_we_o !== 1'b0 || busy_o !== 1'b0 || arm_o !== 1'b0) begin n_fail++; $display("FAIL areset_ctrl got state %0d we %0b busy %0b arm %0b exp 0 0 0 0", state_o, sample_we_o, busy_o, arm_o); end
    n_chk++; if (sample_addr_o !== 4'd0 || seg_count_o !== 8'd0) begin n_fail++; $display("FAIL areset_counts got addr %0d seg %0d exp 0 0", sample_addr_o, seg_count_o); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    start_run(32'd0, 32'd2, 8'd1);
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    n_chk++; if (sample_we_o !== 1'b1 || sample_addr_o !== 4'd0) begin n_fail++; $display("FAIL areset_rerun got we %0b addr %0d exp 1 0", sample_we_o, sample_addr_o); end
    tick();
    tick();
    n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL areset_rerun_done got %0b exp 1", done_o); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_multi_segment();
    test_overflow();
    test_abort_delay();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
